pll_reset_sequencer: RTL

Sequences the 50 MHz-to-100 MHz PLL through reset, lock acquisition and lock qualification, and runs in the reference-clock domain. It holds downstream logic in reset until lock has been stable for a programmed time. It detects loss of lock, re-sequences automatically, retries on lock timeout, and raises a sticky fault when retries are exhausted. It sits between board reset/refclk and the PLL wrapper's rst/locked pins.

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int STATE_W   = 3;
  localparam int CNT_SAT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_SAT_W-1:0] sat_inc(input logic [CNT_SAT_W-1:0] v);
    return (v == {CNT_SAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous status bit.
// Both stages clear to 0 on the synchronous active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the async level, then re-register it to settle metastability.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives the PLL reset, waits for and qualifies lock,
// and holds downstream logic in reset until lock has been stable long enough.
// Lock loss in RUN re-sequences; repeated lock timeouts end in a sticky FAULT.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  // The counter holds the number of cycles already spent in the current
  // state, so "last cycle" of an N-cycle window is N-1.
  localparam logic [CNT_W-1:0]     C_HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_SAT_W-1:0] C_MAX_RETRY   = CNT_SAT_W'(MAX_RETRIES);

  pll_state_e           r_state;
  pll_state_e           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_SAT_W-1:0] r_retry;
  logic [CNT_SAT_W-1:0] w_retry_nxt;
  logic [CNT_SAT_W-1:0] w_retry_inc;
  logic [CNT_SAT_W-1:0] r_loss;
  logic [CNT_SAT_W-1:0] w_loss_nxt;
  logic                 r_pll_rst;
  logic                 r_sys_rst_n;
  logic                 r_ready;
  logic                 r_fault;
  logic                 w_pll_rst_nxt;
  logic                 w_run_nxt;
  logic                 w_fault_nxt;
  logic                 w_locked_s;

  sync_2ff u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // Next-state, counter and status-counter decisions; outputs decode from the
  // next state so they change on the same edge that enters the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_retry_nxt = r_retry;
    w_retry_inc = r_retry + 8'd1;
    w_loss_nxt  = r_loss;

    if (relock_req) begin
      // Restart wins over everything, including a coincident lock loss.
      w_state_nxt = ST_RESET_PLL;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_cnt == C_HOLD_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as a lock.
          if (w_locked_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == C_TMO_LAST) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == C_MAX_RETRY) ? ST_FAULT : ST_RESET_PLL;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_cnt == C_STABLE_LAST) begin
            w_state_nxt = ST_RUN;
            w_retry_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_RESET_PLL;
            w_loss_nxt  = sat_inc(r_loss);
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RESET_PLL;
        end
      endcase
    end

    // Every state change starts its window from zero.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end

    w_pll_rst_nxt = (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
    w_run_nxt     = (w_state_nxt == ST_RUN);
    w_fault_nxt   = (w_state_nxt == ST_FAULT);
  end

  // State, counters and registered outputs; reset parks the PLL in reset.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_state     <= ST_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_rst_n <= w_run_nxt;
      r_ready     <= w_run_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign state         = r_state;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

endmodule
